// File: rtl/divide_dequantize_if.sv
// Handshake and lane bus for divide_dequantize: one beat of NPARALLEL dividends
// plus a shared divisor in, NPARALLEL saturated quotients out.
interface divide_dequantize_if #(
    parameter int NBITS     = 16,
    parameter int NPARALLEL = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [NBITS-1:0] ina [0:NPARALLEL-1];
    logic signed [NBITS-1:0] inb;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [NBITS-1:0] vout [0:NPARALLEL-1];
    logic                    div_zero;

    modport master (
        output in_valid, ina, inb, out_ready,
        input  in_ready, out_valid, vout, div_zero
    );

    modport slave (
        input  in_valid, ina, inb, out_ready,
        output in_ready, out_valid, vout, div_zero
    );
endinterface

// File: rtl/divide_dequantize.sv
// Lane-parallel restoring divider: vout[p] = (ina[p] << NBITS) / inb, saturated.
// Optional macro DEQUANT_ROUND_NEAREST_EN selects round-half-away-from-zero.
module divide_dequantize #(
    parameter int NBITS     = 16,
    parameter int NPARALLEL = 4
) (
    input logic                clk,
    input logic                rst,
    divide_dequantize_if.slave bus
);
    localparam int CW = $clog2(2*NBITS);
    localparam logic signed [NBITS-1:0] MAX_POS = {1'b0, {(NBITS-1){1'b1}}};
    localparam logic signed [NBITS-1:0] MIN_NEG = {1'b1, {(NBITS-1){1'b0}}};
    localparam logic [2*NBITS:0] LIM_POS = {{(NBITS+1){1'b0}}, 1'b0, {(NBITS-1){1'b1}}};
    localparam logic [2*NBITS:0] LIM_NEG = {{(NBITS+1){1'b0}}, 1'b1, {(NBITS-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, PREP, DIV, FIX, DONE} state_t;

    state_t                  state;
    logic [CW-1:0]           count;
    logic                    in_ready;
    logic                    out_valid;
    logic                    div_zero;
    logic signed [NBITS-1:0] vout [0:NPARALLEL-1];

    logic signed [NBITS-1:0] a_q [0:NPARALLEL-1];
    logic signed [NBITS-1:0] b_q;
    logic [NBITS-1:0]        dmag;
    logic [2*NBITS-1:0]      dvd  [0:NPARALLEL-1];
    logic [2*NBITS-1:0]      quot [0:NPARALLEL-1];
    logic [NBITS:0]          rem  [0:NPARALLEL-1];
    logic [NPARALLEL-1:0]    qneg;

    logic [NBITS+1:0]        trial [0:NPARALLEL-1];
    logic [NPARALLEL-1:0]    take;
    logic [2*NBITS:0]        mag   [0:NPARALLEL-1];
    logic signed [NBITS-1:0] res   [0:NPARALLEL-1];

    // Unsigned magnitude; -2^(NBITS-1) maps to 2^(NBITS-1) without overflow.
    function automatic logic [NBITS-1:0] abs_mag(input logic signed [NBITS-1:0] v);
        logic [NBITS-1:0] u;
        u = v;
        return u[NBITS-1] ? (~u + 1'b1) : u;
    endfunction

    function automatic logic signed [NBITS-1:0] saturate(input logic [2*NBITS:0] m,
                                                         input logic neg);
        logic [NBITS-1:0] lo;
        lo = m[NBITS-1:0];
        if (!neg)
            return (m > LIM_POS) ? MAX_POS : lo;
        else
            return (m > LIM_NEG) ? MIN_NEG : (~lo + 1'b1);
    endfunction

    function automatic logic signed [NBITS-1:0] zero_div(input logic signed [NBITS-1:0] a);
        if (a == '0)
            return '0;
        return a[NBITS-1] ? MIN_NEG : MAX_POS;
    endfunction

    always_comb begin
        for (int p = 0; p < NPARALLEL; p++) begin
            trial[p] = {rem[p], dvd[p][2*NBITS-1]};
            take[p]  = (trial[p] >= {2'b00, dmag});
`ifdef DEQUANT_ROUND_NEAREST_EN
            mag[p]   = {1'b0, quot[p]} +
                       (2*NBITS+1)'({rem[p], 1'b0} >= {2'b00, dmag});
`else
            mag[p]   = {1'b0, quot[p]};
`endif
            res[p]   = (b_q == '0) ? zero_div(a_q[p]) : saturate(mag[p], qneg[p]);
        end
    end

    // Control, handshake and result registers; reset aborts any in-flight beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            div_zero  <= 1'b0;
            for (int p = 0; p < NPARALLEL; p++) vout[p] <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    in_ready <= 1'b0;
                    state    <= PREP;
                end
                PREP: begin
                    count <= CW'(2*NBITS-1);
                    state <= DIV;
                end
                DIV: begin
                    if (count == '0) state <= FIX;
                    else             count <= count - 1'b1;
                end
                FIX: begin
                    for (int p = 0; p < NPARALLEL; p++) vout[p] <= res[p];
                    div_zero  <= (b_q == '0);
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Divider datapath: operand capture, magnitude prep, one quotient bit per cycle.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.in_valid) begin
            a_q <= bus.ina;
            b_q <= bus.inb;
        end
        if (state == PREP) begin
            dmag <= abs_mag(b_q);
            for (int p = 0; p < NPARALLEL; p++) begin
                dvd[p]  <= {abs_mag(a_q[p]), {NBITS{1'b0}}};
                rem[p]  <= '0;
                quot[p] <= '0;
                qneg[p] <= a_q[p][NBITS-1] ^ b_q[NBITS-1];
            end
        end
        if (state == DIV) begin
            for (int p = 0; p < NPARALLEL; p++) begin
                dvd[p]  <= dvd[p] << 1;
                rem[p]  <= (NBITS+1)'(take[p] ? (trial[p] - {2'b00, dmag}) : trial[p]);
                quot[p] <= {quot[p][2*NBITS-2:0], take[p]};
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.div_zero  = div_zero;
    assign bus.vout      = vout;
endmodule

// File: tb/tb_divide_dequantize.sv
// Directed bench for divide_dequantize (NBITS=16, NPARALLEL=4) with hand-computed quotients.
module tb_divide_dequantize;
    localparam int NBITS     = 16;
    localparam int NPARALLEL = 4;
    localparam int LAT       = 2*NBITS + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   lat;

    divide_dequantize_if #(.NBITS(NBITS), .NPARALLEL(NPARALLEL)) bus ();

    divide_dequantize #(.NBITS(NBITS), .NPARALLEL(NPARALLEL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_beat(input int a0, input int a1, input int a2, input int a3,
                              input int b);
        bus.ina[0]   = 16'(a0);
        bus.ina[1]   = 16'(a1);
        bus.ina[2]   = 16'(a2);
        bus.ina[3]   = 16'(a3);
        bus.inb      = 16'(b);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(output int cycles);
        cycles = 0;
        while (!bus.out_valid && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    task automatic run_beat(input string tag, input int a0, input int a1, input int a2,
                            input int a3, input int b, input int e0, input int e1,
                            input int e2, input int e3, input int ez);
        check({tag, "_ready"}, int'(bus.in_ready), 1);
        start_beat(a0, a1, a2, a3, b);
        wait_result(lat);
        check({tag, "_lat"}, lat, LAT);
        check({tag, "_v0"}, int'(bus.vout[0]), e0);
        check({tag, "_v1"}, int'(bus.vout[1]), e1);
        check({tag, "_v2"}, int'(bus.vout[2]), e2);
        check({tag, "_v3"}, int'(bus.vout[3]), e3);
        check({tag, "_dz"}, int'(bus.div_zero), ez);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.inb       = '0;
        for (int p = 0; p < NPARALLEL; p++) bus.ina[p] = '0;

        repeat (3) tick();
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_vout0", int'(bus.vout[0]), 0);
        check("rst_div_zero", int'(bus.div_zero), 0);
        rst = 1'b0;
        tick();

        run_beat("basic", 100, -100, 0, 1, 400, 16384, -16384, 0, 163, 0);
        tick();
        check("basic_accept_valid", int'(bus.out_valid), 0);
        check("basic_accept_ready", int'(bus.in_ready), 1);

        run_beat("sat", 100, -100, 2, -32768, 200, 32767, -32768, 655, -32768, 0);
        tick();
        run_beat("mindiv", 1, -1, 32767, 0, -32768, -2, 2, -32768, 0, 0);
        tick();
`ifdef DEQUANT_ROUND_NEAREST_EN
        run_beat("round", 1, -1, 1, 5, 6, 10923, -10923, 10923, 32767, 0);
`else
        run_beat("round", 1, -1, 1, 5, 6, 10922, -10922, 10922, 32767, 0);
`endif
        tick();
        run_beat("divzero", 5, -5, 0, 32767, 0, 32767, -32768, 0, 32767, 1);
        tick();

        bus.out_ready = 1'b0;
        run_beat("bp", 3, -3, 0, 7, 1024, 192, -192, 0, 448, 0);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.ina[0]   = 16'(i * 37 + 1);
            bus.inb      = 16'(i + 2);
            tick();
            check("bp_hold_v0", int'(bus.vout[0]), 192);
            check("bp_hold_valid", int'(bus.out_valid), 1);
            check("bp_hold_ready", int'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("bp_release_valid", int'(bus.out_valid), 0);
        check("bp_release_ready", int'(bus.in_ready), 1);
        repeat (3) tick();
        check("bp_no_second_valid", int'(bus.out_valid), 0);
        check("bp_no_second_ready", int'(bus.in_ready), 1);

        start_beat(9, 9, 9, 9, 7);
        repeat (13) tick();
        check("abort_busy", int'(bus.in_ready), 0);
        rst = 1'b1;
        #1;
        check("abort_valid", int'(bus.out_valid), 0);
        check("abort_ready", int'(bus.in_ready), 1);
        check("abort_vout0", int'(bus.vout[0]), 0);
        tick();
        rst = 1'b0;
        tick();
        run_beat("fresh", 1, 1, 1, 1, 3, 21845, 21845, 21845, 21845, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit reached");
        $fatal(1);
    end
endmodule
